// File: rtl/control_unit.sv
// rtl/control_unit.sv - Mini SRC hardwired step sequencer driving DataPath control strobes.
// Optional mul/div HI/LO sequence enabled by defining CU_MULDIV_EN.
module control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        Run,
  output logic        Pout,
  output logic        MDROut,
  output logic        ZLOout,
  output logic        ZHIout,
  output logic        HIout,
  output logic        LOout,
  output logic        Cout,
  output logic        Rout,
  output logic        BAout,
  output logic        MARen,
  output logic        MDRen,
  output logic        IRen,
  output logic        Yen,
  output logic        Zen,
  output logic        Pen,
  output logic        HIen,
  output logic        LOen,
  output logic        Rin,
  output logic        ConIn,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic [4:0]  alu_control
);

`ifdef CU_MULDIV_EN
  localparam bit MULDIV_EN = 1'b1;
`else
  localparam bit MULDIV_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_NOP, C_ALU, C_UNARY, C_IMM, C_LDI, C_LD, C_ST, C_MULDIV,
    C_BRX, C_JR, C_MFHI, C_MFLO, C_HALT
  } cls_e;

  state_e     state_q, state_d, last_state;
  cls_e       cls;
  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign Run       = (state_q != S_HALT);

  always_comb begin
    cls = C_NOP;
    case (opcode)
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: cls = C_ALU;
      5'd17, 5'd18:        cls = C_UNARY;
      5'd12, 5'd13, 5'd14: cls = C_IMM;
      5'd1:                cls = C_LDI;
      5'd0:                cls = C_LD;
      5'd2:                cls = C_ST;
      5'd15, 5'd16:        cls = MULDIV_EN ? C_MULDIV : C_NOP;
      5'd19:               cls = C_BRX;
      5'd20:               cls = C_JR;
      5'd24:               cls = C_MFHI;
      5'd25:               cls = C_MFLO;
      5'd27:               cls = C_HALT;
      default:             cls = C_NOP;
    endcase
  end

  // Final execute step of each class; Stop is only honoured there.
  always_comb begin
    last_state = S_T3;
    case (cls)
      C_UNARY:             last_state = S_T4;
      C_ALU, C_IMM, C_LDI: last_state = S_T5;
      C_MULDIV, C_BRX:     last_state = S_T6;
      C_LD, C_ST:          last_state = S_T7;
      default:             last_state = S_T3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_HALT:  state_d = S_HALT;
      default: begin
        if (state_q == S_T3 && cls == C_HALT)
          state_d = S_HALT;
        else if (state_q == last_state)
          state_d = Stop ? S_HALT : S_T0;
        else
          state_d = state_e'(state_q + 4'd1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= S_RESET;
    else      state_q <= state_d;
  end

  always_comb begin
    {Pout, MDROut, ZLOout, ZHIout, HIout, LOout, Cout, Rout, BAout} = '0;
    {MARen, MDRen, IRen, Yen, Zen, Pen, HIen, LOen, Rin, ConIn, IncPC} = '0;
    {Read, Write, Gra, Grb, Grc} = '0;
    alu_control = 5'd0;
    case (state_q)
      S_T0: {Pout, MARen, IncPC} = 3'b111;
      S_T1: {Read, MDRen} = 2'b11;
      S_T2: {MDROut, IRen} = 2'b11;
      S_T3: begin
        case (cls)
          C_ALU, C_IMM:  {Grb, Rout, Yen} = 3'b111;
          C_UNARY:       begin {Grb, Rout, Zen} = 3'b111; alu_control = opcode; end
          C_LDI, C_LD,
          C_ST:          {Grb, BAout, Yen} = 3'b111;
          C_MULDIV:      {Gra, Rout, Yen} = 3'b111;
          C_BRX:         {Gra, Rout, ConIn} = 3'b111;
          C_JR:          {Gra, Rout, Pen} = 3'b111;
          C_MFHI:        {HIout, Gra, Rin} = 3'b111;
          C_MFLO:        {LOout, Gra, Rin} = 3'b111;
          default:       ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_ALU:         begin {Grc, Rout, Zen} = 3'b111; alu_control = opcode; end
          C_UNARY:       {ZLOout, Gra, Rin} = 3'b111;
          C_IMM:         begin {Cout, Zen} = 2'b11; alu_control = opcode; end
          C_LDI, C_LD,
          C_ST:          begin {Cout, Zen} = 2'b11; alu_control = 5'b00011; end
          C_MULDIV:      begin {Grb, Rout, Zen} = 3'b111; alu_control = opcode; end
          C_BRX:         {Pout, Yen} = 2'b11;
          default:       ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_ALU, C_IMM,
          C_LDI:         {ZLOout, Gra, Rin} = 3'b111;
          C_LD, C_ST:    {ZLOout, MARen} = 2'b11;
          C_MULDIV:      {ZLOout, LOen} = 2'b11;
          C_BRX:         begin {Cout, Zen} = 2'b11; alu_control = 5'b00011; end
          default:       ;
        endcase
      end
      S_T6: begin
        case (cls)
          C_LD:          {Read, MDRen} = 2'b11;
          C_ST:          {Gra, Rout, MDRen} = 3'b111;
          C_MULDIV:      {ZHIout, HIen} = 2'b11;
          C_BRX:         begin ZLOout = 1'b1; Pen = CON_FF; end
          default:       ;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD:          {MDROut, Gra, Rin} = 3'b111;
          C_ST:          Write = 1'b1;
          default:       ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized bench for control_unit against a micro-program reference model.
module tb_control_unit;

`ifdef CU_MULDIV_EN
  localparam bit MULDIV = 1'b1;
`else
  localparam bit MULDIV = 1'b0;
`endif

  localparam logic [24:0] M_POUT  = 25'd1 << 0,  M_MDROUT = 25'd1 << 1,  M_ZLO   = 25'd1 << 2;
  localparam logic [24:0] M_ZHI   = 25'd1 << 3,  M_HIOUT  = 25'd1 << 4,  M_LOOUT = 25'd1 << 5;
  localparam logic [24:0] M_COUT  = 25'd1 << 6,  M_ROUT   = 25'd1 << 7,  M_BAOUT = 25'd1 << 8;
  localparam logic [24:0] M_MAREN = 25'd1 << 9,  M_MDREN  = 25'd1 << 10, M_IREN  = 25'd1 << 11;
  localparam logic [24:0] M_YEN   = 25'd1 << 12, M_ZEN    = 25'd1 << 13, M_PEN   = 25'd1 << 14;
  localparam logic [24:0] M_HIEN  = 25'd1 << 15, M_LOEN   = 25'd1 << 16, M_RIN   = 25'd1 << 17;
  localparam logic [24:0] M_CONIN = 25'd1 << 18, M_INCPC  = 25'd1 << 19, M_READ  = 25'd1 << 20;
  localparam logic [24:0] M_WRITE = 25'd1 << 21, M_GRA    = 25'd1 << 22, M_GRB   = 25'd1 << 23;
  localparam logic [24:0] M_GRC   = 25'd1 << 24;

  typedef struct packed {
    logic [24:0] s;
    logic [4:0]  alu;
    logic        run;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] IR = '0;
  logic        CON_FF = 1'b0;
  logic        Stop = 1'b0;
  logic        Run, Pout, MDROut, ZLOout, ZHIout, HIout, LOout, Cout, Rout, BAout;
  logic        MARen, MDRen, IRen, Yen, Zen, Pen, HIen, LOen, Rin, ConIn, IncPC;
  logic        Read, Write, Gra, Grb, Grc;
  logic [4:0]  alu_control;
  logic [24:0] got_s;

  int   assert_cnt = 0;
  int   fail_cnt = 0;
  exp_t exp_q[$];
  exp_t prog[$];
  exp_t e_cur;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .clr(clr), .IR(IR), .CON_FF(CON_FF), .Stop(Stop), .Run(Run),
    .Pout(Pout), .MDROut(MDROut), .ZLOout(ZLOout), .ZHIout(ZHIout), .HIout(HIout),
    .LOout(LOout), .Cout(Cout), .Rout(Rout), .BAout(BAout), .MARen(MARen),
    .MDRen(MDRen), .IRen(IRen), .Yen(Yen), .Zen(Zen), .Pen(Pen), .HIen(HIen),
    .LOen(LOen), .Rin(Rin), .ConIn(ConIn), .IncPC(IncPC), .Read(Read),
    .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc), .alu_control(alu_control)
  );

  assign got_s = {Grc, Grb, Gra, Write, Read, IncPC, ConIn, Rin, LOen, HIen, Pen, Zen,
                  Yen, IRen, MDRen, MARen, BAout, Rout, Cout, LOout, HIout, ZHIout,
                  ZLOout, MDROut, Pout};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    assert_cnt++;
    if (got !== want) begin
      fail_cnt++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_cur = exp_q.pop_front();
      check("strobes", {7'd0, got_s}, {7'd0, e_cur.s});
      check("alu_control", {27'd0, alu_control}, {27'd0, e_cur.alu});
      check("Run", {31'd0, Run}, {31'd0, e_cur.run});
    end
  end

  task automatic step(input logic [24:0] s, input logic [4:0] alu);
    exp_t e;
    e.s   = s;
    e.alu = (s & M_ZEN) != 0 ? alu : 5'd0;
    e.run = 1'b1;
    prog.push_back(e);
  endtask

  // Reference micro-program: one entry per clock from T0 to the final execute step.
  task automatic build_prog(input logic [4:0] op, input logic con);
    prog.delete();
    step(M_POUT | M_MAREN | M_INCPC, 0);
    step(M_READ | M_MDREN, 0);
    step(M_MDROUT | M_IREN, 0);
    if (op >= 3 && op <= 11) begin
      step(M_GRB | M_ROUT | M_YEN, 0); step(M_GRC | M_ROUT | M_ZEN, op); step(M_ZLO | M_GRA | M_RIN, 0);
    end else if (op == 17 || op == 18) begin
      step(M_GRB | M_ROUT | M_ZEN, op); step(M_ZLO | M_GRA | M_RIN, 0);
    end else if (op >= 12 && op <= 14) begin
      step(M_GRB | M_ROUT | M_YEN, 0); step(M_COUT | M_ZEN, op); step(M_ZLO | M_GRA | M_RIN, 0);
    end else if (op == 1) begin
      step(M_GRB | M_BAOUT | M_YEN, 0); step(M_COUT | M_ZEN, 3); step(M_ZLO | M_GRA | M_RIN, 0);
    end else if (op == 0 || op == 2) begin
      step(M_GRB | M_BAOUT | M_YEN, 0); step(M_COUT | M_ZEN, 3); step(M_ZLO | M_MAREN, 0);
      if (op == 0) begin
        step(M_READ | M_MDREN, 0); step(M_MDROUT | M_GRA | M_RIN, 0);
      end else begin
        step(M_GRA | M_ROUT | M_MDREN, 0); step(M_WRITE, 0);
      end
    end else if (MULDIV && (op == 15 || op == 16)) begin
      step(M_GRA | M_ROUT | M_YEN, 0); step(M_GRB | M_ROUT | M_ZEN, op);
      step(M_ZLO | M_LOEN, 0); step(M_ZHI | M_HIEN, 0);
    end else if (op == 19) begin
      step(M_GRA | M_ROUT | M_CONIN, 0); step(M_POUT | M_YEN, 0); step(M_COUT | M_ZEN, 3);
      step(M_ZLO | (con ? M_PEN : 25'd0), 0);
    end else if (op == 20) step(M_GRA | M_ROUT | M_PEN, 0);
    else if (op == 24) step(M_HIOUT | M_GRA | M_RIN, 0);
    else if (op == 25) step(M_LOOUT | M_GRA | M_RIN, 0);
    else step(25'd0, 0);
  endtask

  task automatic push_n(input logic run, input int n);
    exp_t e;
    e.s = '0; e.alu = '0; e.run = run;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  // Entered and left one time unit after a rising edge.
  task automatic do_reset();
    clr = 1'b0;
    push_n(1'b1, 2);
    for (int i = 0; i < 2; i++) begin
      Stop = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    clr = 1'b1;
    push_n(1'b1, 1);
    @(posedge clk); #1;
  endtask

  task automatic run_instr(input logic [31:0] ir, input logic con, input logic stop_final,
                           input int stop_from, input int abort_at);
    int   n, last;
    logic op_stop;
    logic halted;
    build_prog(ir[31:27], con);
    last = prog.size() - 1;
    n = (abort_at > 0 && abort_at <= last) ? abort_at : prog.size();
    for (int i = 0; i < n; i++) exp_q.push_back(prog[i]);
    IR = ir;
    CON_FF = con;
    halted = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (stop_from >= 0 && k >= stop_from) op_stop = 1'b1;
      else if (k == last) op_stop = stop_final;
      else op_stop = 1'($urandom_range(0, 1));
      Stop = op_stop;
      if (ir[31:27] != 5'd19) CON_FF = 1'($urandom_range(0, 1));
      if (k == last) halted = op_stop || (ir[31:27] == 5'd27);
      @(posedge clk); #1;
    end
    Stop = 1'b0;
    if (n < prog.size()) begin
      do_reset();
    end else if (halted) begin
      push_n(1'b0, 2);
      repeat (2) begin @(posedge clk); #1; end
      do_reset();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    logic [31:0] ir;
    logic [4:0]  op;
    int          ab;

    build_prog(5'd3, 1'b0);
    check("model add length", prog.size(), 6);
    check("model add T4 strobes", {7'd0, prog[4].s}, {7'd0, M_GRC | M_ROUT | M_ZEN});
    check("model add T4 alu", {27'd0, prog[4].alu}, 32'd3);
    build_prog(5'd2, 1'b0);
    check("model st length", prog.size(), 8);
    check("model st T7", {7'd0, prog[7].s}, 32'h0020_0000);
    build_prog(5'd19, 1'b0);
    check("model brx con0 T6", {7'd0, prog[6].s}, 32'h0000_0004);
    build_prog(5'd19, 1'b1);
    check("model brx con1 T6", {7'd0, prog[6].s}, 32'h0000_4004);
    build_prog(5'd16, 1'b0);
    check("model mul length", prog.size(), MULDIV ? 7 : 4);
    build_prog(5'd26, 1'b0);
    check("model nop length", prog.size(), 4);

    @(posedge clk); #1;
    do_reset();
    run_instr(32'h1A92_0000, 1'b0, 1'b0, -1, 0);
    run_instr({5'd2, 27'h123_4567}, 1'b0, 1'b0, -1, 0);
    run_instr({5'd19, 27'h0}, 1'b0, 1'b0, -1, 0);
    run_instr({5'd19, 27'h0}, 1'b1, 1'b0, -1, 0);
    run_instr({5'd16, 27'h0}, 1'b0, 1'b0, -1, 0);
    run_instr({5'd15, 27'h0}, 1'b0, 1'b0, -1, 0);
    run_instr(32'h1A92_0000, 1'b0, 1'b1, 4, 0);
    run_instr({5'd27, 27'h0}, 1'b0, 1'b0, -1, 0);
    run_instr({5'd0, 27'h0}, 1'b0, 1'b0, -1, 5);

    for (int t = 0; t < 300; t++) begin
      op = 5'($urandom_range(0, 31));
      ir = $urandom;
      ir[31:27] = op;
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_instr(ir, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, -1, ab);
    end

    check("expectation queue drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired Mini SRC control unit that sits directly upstream of `DataPath` and drives every datapath control strobe. It replaces hand-sequenced bench stimulus with a Moore-style step sequencer. The sequencer fetches an instruction (T0–T2), decodes `IR[31:27]`, and runs the per-class execute steps (T3–T7). It then returns to T0, or to HALT on `halt` or a `Stop` request.

## Interface
- No parameters; the opcode map is fixed.
- `clk` in 1 — system clock; the state advances on the rising edge.
- `clr` in 1 — asynchronous, active-low reset.
- `IR` in 32 — datapath IR contents; opcode is `[31:27]`.
- `CON_FF` in 1 — branch condition flip-flop from the datapath.
- `Stop` in 1 — halt request, sampled at instruction end.
- `Run` out 1 — high while not in HALT.
- `Pout`, `MDROut`, `ZLOout`, `ZHIout`, `HIout`, `LOout`, `Cout`, `Rout`, `BAout` out 1 each — bus drive strobes.
- `MARen`, `MDRen`, `IRen`, `Yen`, `Zen`, `Pen`, `HIen`, `LOen`, `Rin`, `ConIn`, `IncPC` out 1 each — register load strobes.
- `Read`, `Write` out 1 each — memory strobes.
- `Gra`, `Grb`, `Grc` out 1 each — register-field selects.
- `alu_control` out 5 — ALU operation code.

## Operation
**Outputs**
- Every output is a combinational function of the registered state and `IR`.
- Any signal not listed for a step is 0.
- `alu_control` is 0 whenever `Zen` = 0.

**States:** RESET, T0–T7, HALT.
- RESET → T0.
- HALT is held until `clr`.

**Fetch**
- T0: `Pout`, `MARen`, `IncPC`.
- T1: `Read`, `MDRen`.
- T2: `MDROut`, `IRen`.

**Execute (from T3; the last listed step returns to T0)**
- Reg-reg ALU ops (add 00011 … shl 01011):
  - T3: `Grb` `Rout` `Yen`.
  - T4: `Grc` `Rout` `Zen`, alu=opcode.
  - T5: `ZLOout` `Gra` `Rin`.
- neg 10001, not 10010:
  - T3: `Grb` `Rout` `Zen`, alu=opcode.
  - T4: `ZLOout` `Gra` `Rin`.
- addi 01100, andi 01101, ori 01110:
  - T3: `Grb` `Rout` `Yen`.
  - T4: `Cout` `Zen`, alu=opcode.
  - T5: `ZLOout` `Gra` `Rin`.
- ldi 00001: same as addi, except T3 uses `BAout` instead of `Rout`, and alu=00011.
- ld 00000:
  - T3: `Grb` `BAout` `Yen`.
  - T4: `Cout` `Zen`, alu=00011.
  - T5: `ZLOout` `MARen`.
  - T6: `Read` `MDRen`.
  - T7: `MDROut` `Gra` `Rin`.
- st 00010:
  - T3–T5: as ld.
  - T6: `Gra` `Rout` `MDRen`.
  - T7: `Write`.
- mul 10000, div 01111:
  - T3: `Gra` `Rout` `Yen`.
  - T4: `Grb` `Rout` `Zen`, alu=opcode.
  - T5: `ZLOout` `LOen`.
  - T6: `ZHIout` `HIen`.
- brx 10011:
  - T3: `Gra` `Rout` `ConIn`.
  - T4: `Pout` `Yen`.
  - T5: `Cout` `Zen`, alu=00011.
  - T6: `ZLOout`, plus `Pen` only if `CON_FF` = 1.
- jr 10100 — T3: `Gra` `Rout` `Pen`.
- mfhi 11000 — T3: `HIout` `Gra` `Rin`.
- mflo 11001 — T3: `LOout` `Gra` `Rin`.
- nop 11010 and every unlisted opcode — T3: no strobes.
- halt 11011 — T3 → HALT.

**Stop handling**
- At the final execute step, if `Stop` = 1, the next state is HALT instead of T0.
- `Stop` has no effect at any other time.

## Timing
- `clr` low forces state RESET immediately (asynchronous); all outputs are 0 and `Run` = 1 while in RESET.
- The first T0 occurs on the first rising edge after `clr` deasserts.
- `clr` asserted mid-instruction aborts the instruction; no strobe from the interrupted step persists past the reset edge.
- Each state lasts exactly one clock.
- `IR` is loaded at the end of T2. The decode in T3+ uses the new value, and `IR` must hold through the last execute step.
- Instruction length in clocks, including fetch:
  - 4: nop, jr, mfhi, mflo, halt.
  - 5: neg, not.
  - 6: ALU, immediate, ldi.
  - 7: mul, div, brx.
  - 8: ld, st.
- `CON_FF` is sampled combinationally during T6 of brx; it must be stable by then, having been set by `ConIn` at the T3 edge.
- In HALT, every strobe is 0 and `Run` = 0.

## Configuration
- `CU_MULDIV_EN` defined: mul and div execute the four-step HI/LO sequence above.
- Undefined: opcodes 10000 and 01111 decode as nop (4 clocks). `HIen`, `LOen` and `ZHIout` are never asserted and may be tied to 0.

## Test plan
- Reset: `clr` low for 2 clocks, then released → all strobes 0 and `Run` = 1 in RESET; `Pout` `MARen` `IncPC` high on the next cycle (T0).
- add R5,R2,R4 (`IR` = 0x1A920000) →
  - T3: `Grb` `Rout` `Yen`.
  - T4: `Grc` `Rout` `Zen`, `alu_control` = 00011.
  - T5: `ZLOout` `Gra` `Rin`.
  - T0 on the 7th clock.
- st (opcode 00010) → `Write` asserted only in T7; the next fetch starts at clock 9.
- brx with `CON_FF` = 0 and then `CON_FF` = 1 → `Pen` absent and present in T6 respectively; `ZLOout` present in both.
- mul with `CU_MULDIV_EN` defined → `LOen` in T5 and `HIen` in T6. With the macro undefined → T3 shows no strobes and the next T0 follows.
- `Stop` raised during T4 of an add → state is HALT after T5 and `Run` = 0. A halt opcode gives `Run` = 0 after T3, and pulsing `clr` low restarts at RESET.
